// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor.
// Latency: n/a (constants only).
// Backpressure: n/a.
package branch_predictor_pkg;

  // 2-bit saturating direction counter states
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Default log2 of the number of BTB entries
  localparam int BP_IDX_BITS = 6;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit ctr_next.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Move one step toward the resolved direction, holding at either end
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters plus branch/mispredict counters.
// Latency: lookup is zero-cycle combinational; updates are visible the cycle after the EX edge.
// Backpressure: ex_stall freezes table and counters; the predictor never stalls fetch.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_br_target,
  input  logic        ex_predict_wrong,
  input  logic        ex_stall,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  // Tag width follows from the index width; kept local so it cannot drift
  localparam int TAG_BITS = 32 - IDX_BITS - 2;
  localparam int ENTRIES  = 1 << IDX_BITS;

  // Flop-based storage so the whole table can be cleared asynchronously
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic                if_hit;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic                upd_en;
  logic [1:0]          ctr_next;
  logic                unused_ex_lsb;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];

  // Byte offset of a resolved PC plays no part in indexing or tagging
  assign unused_ex_lsb = ^ex_pc[1:0];

  assign upd_en = ex_is_branch & ~ex_stall;

  // Lookup reads pre-update contents; no write-to-read bypass
  always_comb begin
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    predict_taken  = ~rst & if_hit & ctr_q[if_idx][1];
    predict_target = predict_taken ? target_q[if_idx] : if_pc + 32'd4;
  end

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  bp_sat_counter u_sat_counter (
    .ctr      (ctr_q[ex_idx]),
    .taken    (ex_taken),
    .ctr_next (ctr_next)
  );

  // Table update: train on hit, allocate on a taken miss, ignore not-taken misses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_next;
        if (ex_taken) target_q[ex_idx] <= ex_br_target;
      end else if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_br_target;
        ctr_q[ex_idx]    <= CTR_WT;
      end
    end
  end

  // Performance counters advance on the same condition as the table, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_en) begin
      branch_count     <= branch_count + 32'd1;
      mispredict_count <= mispredict_count + {31'd0, ex_predict_wrong};
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Latency: inputs driven 1ns after a rising edge, outputs sampled at that point.
// Backpressure: exercises ex_stall and ex_is_branch=0 hold behaviour.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_br_target;
  logic        ex_predict_wrong;
  logic        ex_stall;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int tests;
  int failed;
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .ex_pc            (ex_pc),
    .ex_is_branch     (ex_is_branch),
    .ex_taken         (ex_taken),
    .ex_br_target     (ex_br_target),
    .ex_predict_wrong (ex_predict_wrong),
    .ex_stall         (ex_stall),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One resolved branch through one clock edge, then EX goes idle
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic wrong);
    ex_pc            = pc;
    ex_taken         = tk;
    ex_br_target     = tgt;
    ex_predict_wrong = wrong;
    ex_is_branch     = 1'b1;
    @(posedge clk); #1;
    ex_is_branch     = 1'b0;
    ex_predict_wrong = 1'b0;
    exp_bc = exp_bc + 32'd1;
    if (wrong) exp_mc = exp_mc + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_pc = 32'h0000_0100;
    #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0104) begin
      failed++;
      $display("FAIL reset_in_rst got pt=%0b tgt=%h exp pt=0 tgt=00000104", predict_taken, predict_target);
    end
    #20 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0104) begin
      failed++;
      $display("FAIL reset_lookup got pt=%0b tgt=%h exp pt=0 tgt=00000104", predict_taken, predict_target);
    end
    tests++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      failed++;
      $display("FAIL reset_counts got bc=%0d mc=%0d exp 0 0", branch_count, mispredict_count);
    end
    if_pc = 32'hFFFF_FFFC;
    #1;
    tests++;
    if (predict_target !== 32'h0000_0000) begin
      failed++;
      $display("FAIL pc_wrap got %h exp 00000000", predict_target);
    end
  endtask

  task automatic test_allocate();
    resolve(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
    if_pc = 32'h0000_0100;
    #1;
    tests++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h0000_0080) begin
      failed++;
      $display("FAIL alloc_predict got pt=%0b tgt=%h exp pt=1 tgt=00000080", predict_taken, predict_target);
    end
    tests++;
    if (branch_count !== 32'd1) begin
      failed++;
      $display("FAIL alloc_count got %0d exp 1", branch_count);
    end
  endtask

  task automatic test_counter();
    // Entry at 0x100 has ctr=10; walk it down and saturate at 00
    resolve(32'h0000_0100, 1'b0, 32'h0000_0DEA, 1'b1);  // 10 -> 01
    #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0104) begin
      failed++;
      $display("FAIL ctr_wnt got pt=%0b tgt=%h exp pt=0 tgt=00000104", predict_taken, predict_target);
    end
    resolve(32'h0000_0100, 1'b0, 32'h0000_0DEA, 1'b0);  // 01 -> 00
    resolve(32'h0000_0100, 1'b0, 32'h0000_0DEA, 1'b0);  // 00 stays
    resolve(32'h0000_0100, 1'b1, 32'h0000_0084, 1'b0);  // 00 -> 01
    #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0104) begin
      failed++;
      $display("FAIL ctr_low_sat got pt=%0b tgt=%h exp pt=0 tgt=00000104", predict_taken, predict_target);
    end
    resolve(32'h0000_0100, 1'b1, 32'h0000_0090, 1'b0);  // 01 -> 10, target updated
    #1;
    tests++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h0000_0090) begin
      failed++;
      $display("FAIL ctr_still_valid got pt=%0b tgt=%h exp pt=1 tgt=00000090", predict_taken, predict_target);
    end
    resolve(32'h0000_0100, 1'b1, 32'h0000_0090, 1'b0);  // 10 -> 11
    resolve(32'h0000_0100, 1'b1, 32'h0000_0090, 1'b0);  // 11 stays
    resolve(32'h0000_0100, 1'b0, 32'h0000_0BAD, 1'b0);  // 11 -> 10, target kept
    #1;
    tests++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h0000_0090) begin
      failed++;
      $display("FAIL ctr_high_sat got pt=%0b tgt=%h exp pt=1 tgt=00000090", predict_taken, predict_target);
    end
    // Not-taken miss must not allocate
    resolve(32'h0000_0300, 1'b0, 32'h0000_0700, 1'b0);
    if_pc = 32'h0000_0300;
    #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0304) begin
      failed++;
      $display("FAIL nt_miss_noalloc got pt=%0b tgt=%h exp pt=0 tgt=00000304", predict_taken, predict_target);
    end
    tests++;
    if (branch_count !== exp_bc || mispredict_count !== exp_mc) begin
      failed++;
      $display("FAIL counts_mid got bc=%0d mc=%0d exp bc=%0d mc=%0d", branch_count, mispredict_count, exp_bc, exp_mc);
    end
  endtask

  task automatic test_alias();
    resolve(32'h0000_0200, 1'b1, 32'h0000_0040, 1'b0);
    if_pc = 32'h0000_0100;
    #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0104) begin
      failed++;
      $display("FAIL alias_evicted got pt=%0b tgt=%h exp pt=0 tgt=00000104", predict_taken, predict_target);
    end
    if_pc = 32'h0000_0202;  // low two bits ignored
    #1;
    tests++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h0000_0040) begin
      failed++;
      $display("FAIL alias_new got pt=%0b tgt=%h exp pt=1 tgt=00000040", predict_taken, predict_target);
    end
  endtask

  task automatic test_same_cycle();
    if_pc            = 32'h0000_0104;
    ex_pc            = 32'h0000_0104;
    ex_taken         = 1'b1;
    ex_br_target     = 32'h0000_0500;
    ex_predict_wrong = 1'b0;
    ex_is_branch     = 1'b1;
    #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0108) begin
      failed++;
      $display("FAIL same_cycle_pre got pt=%0b tgt=%h exp pt=0 tgt=00000108", predict_taken, predict_target);
    end
    @(posedge clk); #1;
    ex_is_branch = 1'b0;
    exp_bc = exp_bc + 32'd1;
    tests++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h0000_0500) begin
      failed++;
      $display("FAIL same_cycle_post got pt=%0b tgt=%h exp pt=1 tgt=00000500", predict_taken, predict_target);
    end
  endtask

  task automatic test_stall();
    if_pc            = 32'h0000_0108;
    ex_pc            = 32'h0000_0108;
    ex_taken         = 1'b1;
    ex_br_target     = 32'h0000_0600;
    ex_predict_wrong = 1'b1;
    ex_stall         = 1'b1;
    ex_is_branch     = 1'b1;
    @(posedge clk); #1;
    ex_is_branch = 1'b0;
    ex_stall     = 1'b0;
    @(posedge clk); #1;  // not a branch: also holds
    ex_predict_wrong = 1'b0;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_010C) begin
      failed++;
      $display("FAIL stall_table got pt=%0b tgt=%h exp pt=0 tgt=0000010c", predict_taken, predict_target);
    end
    tests++;
    if (branch_count !== exp_bc || mispredict_count !== exp_mc) begin
      failed++;
      $display("FAIL stall_counts got bc=%0d mc=%0d exp bc=%0d mc=%0d", branch_count, mispredict_count, exp_bc, exp_mc);
    end
  endtask

  task automatic test_counts_and_reset();
    logic [31:0] bc0;
    logic [31:0] mc0;
    logic [4:0]  wrong_pat;
    bc0 = exp_bc;
    mc0 = exp_mc;
    wrong_pat = 5'b01101;  // bit i = ex_predict_wrong of update i: 1,0,1,1,0
    for (int i = 0; i < 5; i++)
      resolve(32'h0000_010C, 1'b1, 32'h0000_0700, wrong_pat[i]);
    tests++;
    if (branch_count !== bc0 + 32'd5 || mispredict_count !== mc0 + 32'd3) begin
      failed++;
      $display("FAIL counts_five got bc=%0d mc=%0d exp bc=%0d mc=%0d", branch_count, mispredict_count, bc0 + 32'd5, mc0 + 32'd3);
    end
    if_pc = 32'h0000_010C;
    #1;
    tests++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h0000_0700) begin
      failed++;
      $display("FAIL pre_reset_entry got pt=%0b tgt=%h exp pt=1 tgt=00000700", predict_taken, predict_target);
    end
    #1 rst = 1'b1;  // mid-cycle, away from any edge
    #1;
    tests++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      failed++;
      $display("FAIL async_reset_counts got bc=%0d mc=%0d exp 0 0", branch_count, mispredict_count);
    end
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0110) begin
      failed++;
      $display("FAIL async_reset_lookup got pt=%0b tgt=%h exp pt=0 tgt=00000110", predict_taken, predict_target);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    if_pc = 32'h0000_0104;
    #1;
    tests++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h0000_0108) begin
      failed++;
      $display("FAIL post_reset_entry got pt=%0b tgt=%h exp pt=0 tgt=00000108", predict_taken, predict_target);
    end
  endtask

  initial begin
    tests            = 0;
    failed           = 0;
    exp_bc           = 32'd0;
    exp_mc           = 32'd0;
    ex_pc            = 32'd0;
    ex_is_branch     = 1'b0;
    ex_taken         = 1'b0;
    ex_br_target     = 32'd0;
    ex_predict_wrong = 1'b0;
    ex_stall         = 1'b0;
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_stall();
    test_counts_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: direct-mapped branch target buffer (BTB) plus a 2-bit saturating-counter history table.
- Combinationally supplies predict_taken and the predicted next PC to IF for the current fetch PC. predict_taken travels down the pipeline to the EX-stage branch decision logic.
- Updated on the clock edge from the EX-stage resolution (is_branch, taken, predict_wrong, resolved target).
- Keeps 32-bit branch and misprediction counters for performance measurement.

Parameters:
- IDX_BITS, 6, log2 of BTB entries (64 entries).
- TAG_BITS, 32-IDX_BITS-2, tag width. Derived; not to be overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_pc  input  32  PC being fetched this cycle
- predict_taken  output  1  prediction for if_pc (combinational)
- predict_target  output  32  predicted next PC for if_pc (combinational)
- ex_pc  input  32  PC of the instruction resolved in EX
- ex_is_branch  input  1  EX holds a conditional branch; update enable
- ex_taken  input  1  resolved direction
- ex_br_target  input  32  resolved taken-target (PC+imm)
- ex_predict_wrong  input  1  EX misprediction flag
- ex_stall  input  1  EX held this cycle; suppresses update and counting
- branch_count  output  32  number of branches resolved
- mispredict_count  output  32  number of mispredictions

Behaviour:
- Index and tag:
  - idx = pc[IDX_BITS+1:2]
  - tag = pc[31:IDX_BITS+2]
  - pc[1:0] is ignored.
- Entry contents: valid (1), tag (TAG_BITS), target (32), ctr (2).
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag match.
  - predict_taken = hit & ctr[1].
  - predict_target = predict_taken ? target[idx] : if_pc+4. The +4 is 32-bit and wraps at 0xFFFFFFFC -> 0x00000000.
- Update happens on the rising clk edge when ex_is_branch=1 and ex_stall=0:
  - Hit on ex_pc, ex_taken=1: ctr saturating increment (11 stays 11); target <= ex_br_target.
  - Hit on ex_pc, ex_taken=0: ctr saturating decrement (00 stays 00); target unchanged; entry stays valid.
  - Miss on ex_pc, ex_taken=1: allocate, overwriting any aliasing entry. valid=1, tag=ex_pc tag, target=ex_br_target, ctr=10.
  - Miss on ex_pc, ex_taken=0: no table change.
- Counters, on the same update condition:
  - branch_count += 1.
  - mispredict_count += ex_predict_wrong.
  - Both wrap modulo 2^32.
- ex_is_branch=0 or ex_stall=1: table and counters hold.
- Same-cycle lookup and update of the same idx: lookup returns pre-update contents. There is no write-to-read bypass; the new value is visible from the next cycle.
- Reset (asynchronous, any time, including mid-update):
  - All valid=0, all ctr=01, all tags/targets=0.
  - branch_count=0, mispredict_count=0.
  - While rst is high: predict_taken=0 and predict_target=if_pc+4.
- Storage is flip-flops, not inferred RAM, because an asynchronous clear of all entries is required.

Decomposition:
- Shared header (the existing parameters include file):
  - Counter state constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Default BP_IDX_BITS=6.
- One sub-module: bp_sat_counter. Purely combinational next-state for a 2-bit saturating counter. Inputs ctr, taken; output ctr_next. Instantiated once on the update path.

Test Plan:
- Reset, then if_pc=0x00000100 -> predict_taken=0, predict_target=0x00000104; both counts 0.
- Update ex_pc=0x100, ex_taken=1, ex_br_target=0x80 (miss) -> next cycle if_pc=0x100 gives predict_taken=1, predict_target=0x80; branch_count=1.
- Same branch resolved not-taken twice (ctr 10->01->00), then taken once -> predictions taken, not-taken, not-taken; ctr ends 01; entry stays valid.
- Aliasing: ex_pc=0x100 taken, then ex_pc=0x200 taken with target 0x40 (same idx for IDX_BITS=6, different tag) -> if_pc=0x100 misses (predict_taken=0); if_pc=0x200 predicts 0x40.
- Same-cycle: if_pc=ex_pc=0x100 with allocate update -> predict_taken=0 that cycle, 1 next cycle. ex_stall=1 with ex_is_branch=1 -> no change to table or counts.
- 5 updates with ex_predict_wrong=1,0,1,1,0, then assert rst asynchronously mid-cycle -> mispredict_count=3, branch_count=5 before reset; all zero and the prior entry misses immediately after.
